// File: rtl/ppu_pkg.sv
// Shared types for the post-processing / halo exchange engine:
// exchange directions, activation bitwidths with their saturation limits,
// and the controller states.
package ppu_pkg;

   localparam int NUM_DIRS = 8;

   // Exchange port order; the numeric value is the port index.
   typedef enum logic [2:0] {
      DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
   } direction_e;

   typedef enum logic [1:0] {
      BW_8, BW_4, BW_2, BW_1
   } bitwidth_e;

   typedef enum logic [1:0] {
      ST_IDLE, ST_SCAN, ST_DRAIN, ST_WAIT_NEIGHBORS
   } state_e;

   // Largest non-negative value representable at a given activation width.
   function automatic logic [7:0] sat_max(bitwidth_e bw);
      case (bw)
         BW_8:    return 8'd127;
         BW_4:    return 8'd15;
         BW_2:    return 8'd3;
         default: return 8'd1;
      endcase
   endfunction

endpackage

// File: rtl/ppu_halo_exchanger_if.sv
// Buffer read port plus the 8-way neighbour exchange bundle. The engine
// is the master; the tile buffer and the neighbour tiles sit on the slave side.
interface ppu_halo_exchanger_if #(
   parameter int CW             = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int NEIGHBOR_COUNT = 8
);
   logic [CW-1:0]             buffer_read_row;
   logic [CW-1:0]             buffer_read_column;
   logic                      buffer_read_enable;
   logic [DATA_WIDTH-1:0]     buffer_data_read;

   logic [NEIGHBOR_COUNT-1:0] neighbor_cts;
   logic [NEIGHBOR_COUNT-1:0] neighbor_exchange_done;
   logic [DATA_WIDTH-1:0]     neighbor_output_value  [NEIGHBOR_COUNT];
   logic [CW-1:0]             neighbor_output_row    [NEIGHBOR_COUNT];
   logic [CW-1:0]             neighbor_output_column [NEIGHBOR_COUNT];
   logic [NEIGHBOR_COUNT-1:0] neighbor_output_write_enable;

   modport master (
      output buffer_read_row, buffer_read_column, buffer_read_enable,
      input  buffer_data_read,
      input  neighbor_cts, neighbor_exchange_done,
      output neighbor_output_value, neighbor_output_row,
      output neighbor_output_column, neighbor_output_write_enable
   );

   modport slave (
      input  buffer_read_row, buffer_read_column, buffer_read_enable,
      output buffer_data_read,
      output neighbor_cts, neighbor_exchange_done,
      input  neighbor_output_value, neighbor_output_row,
      input  neighbor_output_column, neighbor_output_write_enable
   );
endinterface

// File: rtl/ppu_halo_classifier.sv
// Maps a tile-local coordinate to the set of neighbours whose receptive
// field overlaps it. Tiles narrower than 2H can flag opposite bands at once.
module ppu_halo_classifier
   import ppu_pkg::*;
#(
   parameter int CW             = 8,
   parameter int NEIGHBOR_COUNT = NUM_DIRS
) (
   input  logic [CW-1:0]             row,
   input  logic [CW-1:0]             column,
   input  logic [1:0]                halo,
   input  logic [CW:0]               tile_rows,
   input  logic [CW:0]               tile_columns,
   input  logic [NEIGHBOR_COUNT-1:0] neighbor_present,
   output logic [NEIGHBOR_COUNT-1:0] destination_mask
);
   // Two spare bits so r+H never wraps against the extent.
   localparam int XW = CW + 2;

   logic [XW-1:0]       rx, cx, hx, rows_x, cols_x;
   logic                in_n, in_s, in_w, in_e;
   logic [NUM_DIRS-1:0] raw;

   assign rx     = XW'(row);
   assign cx     = XW'(column);
   assign hx     = XW'(halo);
   assign rows_x = XW'(tile_rows);
   assign cols_x = XW'(tile_columns);

   // Edge bands; r >= rows-H is rewritten as r+H >= rows to avoid underflow.
   assign in_n = rx < hx;
   assign in_s = (rx + hx) >= rows_x;
   assign in_w = cx < hx;
   assign in_e = (cx + hx) >= cols_x;

   // Edge and corner membership, then masked by which neighbours exist.
   always_comb begin
      // NOTE: assign every always_comb output up front so no path can infer a latch.
      raw         = '0;
      raw[DIR_N]  = in_n;
      raw[DIR_NE] = in_n & in_e;
      raw[DIR_E]  = in_e;
      raw[DIR_SE] = in_s & in_e;
      raw[DIR_S]  = in_s;
      raw[DIR_SW] = in_s & in_w;
      raw[DIR_W]  = in_w;
      raw[DIR_NW] = in_n & in_w;
   end

   assign destination_mask = raw & neighbor_present;

endmodule

// File: rtl/ppu_halo_exchanger.sv
// Scans the tile output buffer, applies ReLU + saturation, forwards non-zero
// halo elements to neighbour tiles under clear-to-send, then runs the
// exchange_done / cycle_done barrier.
// Pipeline: issue read (t) -> data + classify (t+1) -> registered send (t+2).
module ppu_halo_exchanger
   import ppu_pkg::*;
#(
   parameter int TILE_SIZE      = 256,
   parameter int NEIGHBOR_COUNT = 8,
   parameter int DATA_WIDTH     = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [1:0]                          bitwidth,
   input  logic [2:0]                          kernel_size,
   input  logic [$clog2(TILE_SIZE):0]          tile_rows,
   input  logic [$clog2(TILE_SIZE):0]          tile_columns,
   input  logic [NEIGHBOR_COUNT-1:0]           neighbor_present,
   input  logic                                channel_group_done,
   ppu_halo_exchanger_if.master                bus,
   output logic                                exchange_done,
   output logic                                cycle_done,
   output logic                                busy
);
   localparam int CW = $clog2(TILE_SIZE);
   localparam int DW = DATA_WIDTH;
   localparam logic [CW:0] EXT_ONE = (CW+1)'(1);

   state_e                    state, next_state;
   logic [1:0]                halo;
   logic [CW-1:0]             rd_row, rd_col;
   logic                      issue, start_scan, last_issue, col_last;
   logic                      s1_valid, s1_fresh;
   logic [CW-1:0]             s1_row, s1_col;
   logic [DW-1:0]             hold_data, s1_data, s1_result, sat_limit;
   logic [NEIGHBOR_COUNT-1:0] s1_mask, out_mask;
   logic                      out_valid;
   logic [DW-1:0]             out_value;
   logic [CW-1:0]             out_row, out_col;
   logic                      send_ok, stall, pipe_empty, all_done;
   logic                      exchange_done_d, cycle_done_d;

   assign halo       = kernel_size[2:1];
   assign col_last   = ({1'b0, rd_col} == tile_columns - EXT_ONE);
   assign last_issue = ({1'b0, rd_row} == tile_rows - EXT_ONE) && col_last;

   // The held element may leave only when every one of its destinations is ready.
   assign send_ok    = &(bus.neighbor_cts | ~out_mask);
   assign stall      = out_valid & ~send_ok;
   // Nothing left to send after this cycle.
   assign pipe_empty = !s1_valid && !stall;
   assign all_done   = &(bus.neighbor_exchange_done | ~neighbor_present);

   // Controller state register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Controller next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:           if (channel_group_done)
                               next_state = (halo == 2'd0) ? ST_WAIT_NEIGHBORS : ST_SCAN;
         ST_SCAN:           if (issue && last_issue) next_state = ST_DRAIN;
         ST_DRAIN:          if (pipe_empty) next_state = ST_WAIT_NEIGHBORS;
         ST_WAIT_NEIGHBORS: if (all_done) next_state = ST_IDLE;
         default:           next_state = ST_IDLE;
      endcase
   end

   // Controller outputs; exchange_done stays up through the cycle_done pulse.
   always_comb begin
      issue           = (state == ST_SCAN) && !stall;
      start_scan      = (state == ST_IDLE) && channel_group_done && (halo != 2'd0);
      exchange_done_d = (next_state == ST_WAIT_NEIGHBORS) || (state == ST_WAIT_NEIGHBORS);
      cycle_done_d    = (state == ST_WAIT_NEIGHBORS) && all_done;
   end

   // ReLU then clamp to the active bitwidth; read data comes live or from the hold register.
   always_comb begin
      sat_limit = DW'(sat_max(bitwidth_e'(bitwidth)));
      s1_data   = s1_fresh ? bus.buffer_data_read : hold_data;
      s1_result = s1_data;
      if (s1_data[DW-1])            s1_result = '0;
      else if (s1_data > sat_limit) s1_result = sat_limit;
   end

   ppu_halo_classifier #(
      .CW             (CW),
      .NEIGHBOR_COUNT (NEIGHBOR_COUNT)
   ) u_classifier (
      .row              (s1_row),
      .column           (s1_col),
      .halo             (halo),
      .tile_rows        (tile_rows),
      .tile_columns     (tile_columns),
      .neighbor_present (neighbor_present),
      .destination_mask (s1_mask)
   );

   // Scan counters, read/output pipeline and barrier outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_row        <= '0;
         rd_col        <= '0;
         s1_valid      <= 1'b0;
         s1_fresh      <= 1'b0;
         s1_row        <= '0;
         s1_col        <= '0;
         hold_data     <= '0;
         out_valid     <= 1'b0;
         out_mask      <= '0;
         out_value     <= '0;
         out_row       <= '0;
         out_col       <= '0;
         exchange_done <= 1'b0;
         cycle_done    <= 1'b0;
      end else begin
         if (start_scan) begin
            rd_row <= '0;
            rd_col <= '0;
         end else if (issue && !last_issue) begin
            if (col_last) begin
               rd_col <= '0;
               rd_row <= rd_row + CW'(1);
            end else begin
               rd_col <= rd_col + CW'(1);
            end
         end

         if (!stall) begin
            s1_valid  <= issue;
            s1_fresh  <= issue;
            s1_row    <= rd_row;
            s1_col    <= rd_col;
            // Zero results and elements with no live destination never occupy the send stage.
            out_valid <= s1_valid && (s1_result != '0) && (s1_mask != '0);
            out_mask  <= s1_mask;
            out_value <= s1_result;
            out_row   <= s1_row;
            out_col   <= s1_col;
         end else if (s1_fresh) begin
            // Buffer data is only valid one cycle; park it until the stall clears.
            hold_data <= bus.buffer_data_read;
            s1_fresh  <= 1'b0;
         end

         exchange_done <= exchange_done_d;
         cycle_done    <= cycle_done_d;
      end
   end

   assign busy                   = (state != ST_IDLE);
   assign bus.buffer_read_enable = issue;
   assign bus.buffer_read_row    = rd_row;
   assign bus.buffer_read_column = rd_col;
   assign bus.neighbor_output_write_enable = (out_valid && send_ok) ? out_mask : '0;

   for (genvar d = 0; d < NEIGHBOR_COUNT; d++) begin : g_port
      assign bus.neighbor_output_value[d]  = out_value;
      assign bus.neighbor_output_row[d]    = out_row;
      assign bus.neighbor_output_column[d] = out_col;
   end

endmodule

// File: tb/tb_ppu_halo_exchanger.sv
// Directed bench for ppu_halo_exchanger on a 4x4 tile. Cycle 0 is the cycle
// right after the edge that samples channel_group_done (first read strobe).
module tb_ppu_halo_exchanger;
   import ppu_pkg::*;

   localparam int TS = 256;
   localparam int NC = 8;
   localparam int DW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    bitwidth;
   logic [2:0]    kernel_size;
   logic [CW:0]   tile_rows, tile_columns;
   logic [NC-1:0] neighbor_present;
   logic          channel_group_done;
   logic          exchange_done, cycle_done, busy;

   ppu_halo_exchanger_if #(.CW(CW), .DATA_WIDTH(DW), .NEIGHBOR_COUNT(NC)) bus ();

   ppu_halo_exchanger #(.TILE_SIZE(TS), .NEIGHBOR_COUNT(NC), .DATA_WIDTH(DW)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .bitwidth           (bitwidth),
      .kernel_size        (kernel_size),
      .tile_rows          (tile_rows),
      .tile_columns       (tile_columns),
      .neighbor_present   (neighbor_present),
      .channel_group_done (channel_group_done),
      .bus                (bus),
      .exchange_done      (exchange_done),
      .cycle_done         (cycle_done),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   // Tile buffer model: one-cycle read latency.
   logic signed [7:0] mem [4][4];
   always @(posedge clk)
      if (bus.buffer_read_enable)
         bus.buffer_data_read <= mem[bus.buffer_read_row[1:0]][bus.buffer_read_column[1:0]];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int at;

   // Strobe log filled by the monitor.
   int   rd_cnt, dup_cnt, bad_val, bad_band;
   int   cnt     [NC];
   int   arr_cyc [NC][16];
   logic seen    [NC][16];
   logic [7:0] exp_val;
   int   exp_cnt_full [NC] = '{4, 1, 4, 1, 4, 1, 4, 1};

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Band membership straight from the edge/corner rules.
   function automatic bit in_band(int d, int r, int c);
      int  h;
      bit  n, s, w, e;
      h = int'(kernel_size) / 2;
      n = r < h;
      s = r >= int'(tile_rows) - h;
      w = c < h;
      e = c >= int'(tile_columns) - h;
      case (d)
         0: return n;
         1: return n && e;
         2: return e;
         3: return s && e;
         4: return s;
         5: return s && w;
         6: return w;
         default: return n && w;
      endcase
   endfunction

   always @(negedge clk) begin
      if (bus.buffer_read_enable) rd_cnt++;
      for (int d = 0; d < NC; d++) begin
         if (bus.neighbor_output_write_enable[d]) begin
            int r, c, id;
            r  = int'(bus.neighbor_output_row[d]);
            c  = int'(bus.neighbor_output_column[d]);
            id = r * 4 + c;
            cnt[d]++;
            if (bus.neighbor_output_value[d] != exp_val) bad_val++;
            if (r > 3 || c > 3 || !in_band(d, r, c)) bad_band++;
            else begin
               if (seen[d][id]) dup_cnt++;
               seen[d][id]    = 1'b1;
               arr_cyc[d][id] = cyc;
            end
         end
      end
   end

   task automatic clear_log();
      rd_cnt = 0; dup_cnt = 0; bad_val = 0; bad_band = 0;
      for (int d = 0; d < NC; d++) begin
         cnt[d] = 0;
         for (int i = 0; i < 16; i++) begin
            seen[d][i]    = 1'b0;
            arr_cyc[d][i] = -1;
         end
      end
   endtask

   function automatic int total_strobes();
      int t = 0;
      for (int d = 0; d < NC; d++) t += cnt[d];
      return t;
   endfunction

   task automatic fill(input logic signed [7:0] v);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mem[r][c] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start();
      clear_log();
      channel_group_done = 1'b1;
      @(posedge clk);
      #1;
      channel_group_done = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_exdone(input int budget, output int when);
      while (!exchange_done && cyc < budget) tick();
      when = exchange_done ? cyc : -1;
   endtask

   task automatic finish_barrier(input string tag);
      int n = 0;
      bus.neighbor_exchange_done = neighbor_present;
      while (!cycle_done && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_cycle_done"}, int'(cycle_done), 1);
      tick();
      tick();
      check({tag, "_idle_busy"}, int'(busy), 0);
      check({tag, "_idle_exdone"}, int'(exchange_done), 0);
      bus.neighbor_exchange_done = '0;
   endtask

   task automatic check_full_counts(input string tag);
      for (int d = 0; d < NC; d++)
         check($sformatf("%s_cnt_dir%0d", tag, d), cnt[d], exp_cnt_full[d]);
      check({tag, "_dup"}, dup_cnt, 0);
      check({tag, "_bad_val"}, bad_val, 0);
      check({tag, "_bad_band"}, bad_band, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n            = 1'b0;
      bitwidth           = 2'd0;
      kernel_size        = 3'd3;
      tile_rows          = 9'd4;
      tile_columns       = 9'd4;
      neighbor_present   = 8'hFF;
      channel_group_done = 1'b0;
      bus.neighbor_cts           = 8'hFF;
      bus.neighbor_exchange_done = 8'h00;
      exp_val = 8'd5;
      fill(8'sd5);
      clear_log();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_exdone", int'(exchange_done), 0);
      check("rst_cycle_done", int'(cycle_done), 0);
      check("rst_read_en", int'(bus.buffer_read_enable), 0);
      check("rst_we", int'(bus.neighbor_output_write_enable), 0);
      check("rst_value0", int'(bus.neighbor_output_value[0]), 0);
      reset_n = 1'b1;
      tick();

      // T1: 4x4, kernel 3, all 5, cts high; a stray start at cycle 5 is ignored.
      start();
      check("t1_read_en_c0", int'(bus.buffer_read_enable), 1);
      check("t1_read_row_c0", int'(bus.buffer_read_row), 0);
      check("t1_read_col_c0", int'(bus.buffer_read_column), 0);
      while (!exchange_done && cyc < 100) begin
         channel_group_done = (cyc == 5);
         tick();
      end
      channel_group_done = 1'b0;
      at = exchange_done ? cyc : -1;
      check("t1_exdone_cycle", at, 18);
      check("t1_reads", rd_cnt, 16);
      check("t1_total", total_strobes(), 20);
      check_full_counts("t1");
      check("t1_00_N_cycle", arr_cyc[0][0], 2);
      check("t1_00_W_cycle", arr_cyc[6][0], 2);
      check("t1_00_NW_cycle", arr_cyc[7][0], 2);
      check("t1_00_not_NE", int'(seen[1][0]), 0);
      finish_barrier("t1");

      // T2: negative corner, zeros elsewhere -> nothing sent.
      fill(8'sd0);
      mem[0][0] = -8'sd7;
      exp_val   = 8'd0;
      start();
      wait_exdone(100, at);
      check("t2_exdone_cycle", at, 18);
      check("t2_total", total_strobes(), 0);
      check("t2_reads", rd_cnt, 16);
      finish_barrier("t2");

      // T3: 4-bit saturation of 100 at the SE corner.
      bitwidth  = 2'd1;
      fill(8'sd0);
      mem[3][3] = 8'sd100;
      exp_val   = 8'd15;
      start();
      wait_exdone(100, at);
      check("t3_cnt_E", cnt[2], 1);
      check("t3_cnt_SE", cnt[3], 1);
      check("t3_cnt_S", cnt[4], 1);
      check("t3_total", total_strobes(), 3);
      check("t3_bad_val", bad_val, 0);
      check("t3_SE_cycle", arr_cyc[3][15], 17);
      finish_barrier("t3");
      bitwidth = 2'd0;

      // T4: cts[N] low for cycles 2..11 stalls (0,0) on every port by 10 cycles.
      fill(8'sd5);
      exp_val = 8'd5;
      start();
      while (!exchange_done && cyc < 200) begin
         bus.neighbor_cts[0] = !(cyc >= 2 && cyc < 12);
         tick();
      end
      bus.neighbor_cts = 8'hFF;
      at = exchange_done ? cyc : -1;
      check("t4_exdone_cycle", at, 28);
      check("t4_00_N_cycle", arr_cyc[0][0], 12);
      check("t4_00_W_cycle", arr_cyc[6][0], 12);
      check("t4_00_NW_cycle", arr_cyc[7][0], 12);
      check("t4_reads", rd_cnt, 16);
      check_full_counts("t4");
      finish_barrier("t4");

      // T5: kernel 1, only N..SE present, barrier at cycle 5.
      kernel_size      = 3'd1;
      neighbor_present = 8'h0F;
      start();
      check("t5_exdone_c0", int'(exchange_done), 1);
      check("t5_read_en_c0", int'(bus.buffer_read_enable), 0);
      while (cyc < 5) tick();
      check("t5_cycle_done_c5", int'(cycle_done), 0);
      bus.neighbor_exchange_done = 8'h0F;
      tick();
      check("t5_cycle_done_c6", int'(cycle_done), 1);
      check("t5_exdone_c6", int'(exchange_done), 1);
      tick();
      check("t5_cycle_done_c7", int'(cycle_done), 0);
      check("t5_exdone_c7", int'(exchange_done), 0);
      check("t5_busy_c7", int'(busy), 0);
      check("t5_reads", rd_cnt, 0);
      bus.neighbor_exchange_done = 8'h00;
      kernel_size      = 3'd3;
      neighbor_present = 8'hFF;
      tick();

      // T6: reset in the middle of SCAN, then a clean restart.
      start();
      while (cyc < 5) tick();
      reset_n = 1'b0;
      #1;
      check("t6_rst_read_en", int'(bus.buffer_read_enable), 0);
      check("t6_rst_we", int'(bus.neighbor_output_write_enable), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_row", int'(bus.buffer_read_row), 0);
      check("t6_rst_col", int'(bus.buffer_read_column), 0);
      check("t6_rst_value", int'(bus.neighbor_output_value[2]), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      start();
      check("t6_restart_read_en", int'(bus.buffer_read_enable), 1);
      check("t6_restart_row", int'(bus.buffer_read_row), 0);
      check("t6_restart_col", int'(bus.buffer_read_column), 0);
      wait_exdone(100, at);
      check("t6_exdone_cycle", at, 18);
      check("t6_total", total_strobes(), 20);
      finish_barrier("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ppu_halo_exchanger.md
# ppu_halo_exchanger

Output-side post-processing engine for one PE tile. On `channel_group_done` it scans the tile's output buffer row-major and applies ReLU plus bitwidth saturation. Every non-zero result in the kernel halo band is pushed to the affected neighbour tiles over the 8-way exchange ports under per-neighbour clear-to-send flow control. It then runs the `exchange_done` / `cycle_done` barrier with the neighbours.

## Interface
Parameters:
- `TILE_SIZE`, 256: max rows/columns per tile; coordinate width `CW = $clog2(TILE_SIZE)`.
- `NEIGHBOR_COUNT`, 8: exchange directions, order 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW.
- `DATA_WIDTH`, 8: buffer and exchange value width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `reset_n`  in  1  asynchronous active-low reset.
- `bitwidth`  in  2  0→8b, 1→4b, 2→2b, 3→1b.
- `kernel_size`  in  3  odd, 1..7; halo `H = kernel_size>>1`.
- `tile_rows`, `tile_columns`  in  CW+1 each  active extent, 1..TILE_SIZE.
- `neighbor_present`  in  NEIGHBOR_COUNT  1 = neighbour exists.
- `channel_group_done`  in  1  start pulse.
- `buffer_read_row`, `buffer_read_column`  out  CW each  read address.
- `buffer_read_enable`  out  1  read strobe.
- `buffer_data_read`  in  DATA_WIDTH  signed; valid the cycle after the strobe.
- `neighbor_cts[NEIGHBOR_COUNT]`  in  1  neighbour can accept.
- `neighbor_exchange_done[NEIGHBOR_COUNT]`  in  1  neighbour finished sending.
- `neighbor_output_value[NEIGHBOR_COUNT]`  out  DATA_WIDTH  outgoing value.
- `neighbor_output_row[NEIGHBOR_COUNT]`, `neighbor_output_column[NEIGHBOR_COUNT]`  out  CW each  outgoing coordinates.
- `neighbor_output_write_enable[NEIGHBOR_COUNT]`  out  1  outgoing strobe.
- `exchange_done`  out  1  this tile finished sending.
- `cycle_done`  out  1  barrier complete, one-cycle pulse.
- `busy`  out  1  not IDLE.

## Operation
- States: IDLE, SCAN, DRAIN, WAIT_NEIGHBORS.
- IDLE:
  - `channel_group_done` → SCAN with row=col=0.
  - If `H==0` it goes straight to WAIT_NEIGHBORS and no reads are issued.
  - `channel_group_done` in any other state is ignored.
- SCAN:
  - Issues one read per unstalled cycle, row-major.
  - After issuing (`tile_rows-1`, `tile_columns-1`) it goes to DRAIN.
- DRAIN: when the pipeline is empty, go to WAIT_NEIGHBORS.
- WAIT_NEIGHBORS:
  - `exchange_done` is held high.
  - When every d with `neighbor_present[d]` has `neighbor_exchange_done[d]` high in the same cycle: pulse `cycle_done` for one cycle, go to IDLE, drop `exchange_done`.
- Post-processing:
  - v<0 → 0.
  - Otherwise saturate to max 127, 15, 3, 1 for `bitwidth` 0..3; zero-extend to DATA_WIDTH.
  - Results equal to 0 are never sent (sparse output).
- Classification of (r,c):
  - Edge bands: N if r<H; S if r≥tile_rows−H; W if c<H; E if c≥tile_columns−H.
  - Corner directions: NE=N∧E, SE=S∧E, SW=S∧W, NW=N∧W.
  - A corner element goes to up to 3 neighbours in the same cycle.
  - Destinations are masked by `neighbor_present`.
  - Extents <2H may mark both N and S; send to both.
- Sent row/column are sender-local coordinates; the receiver remaps them.

## Timing
- Read latency is 1. A strobe at cycle t produces `neighbor_output_write_enable` at t+2 (output registered).
- Stall:
  - If any destination of the element in the output stage has `neighbor_cts` low, outputs hold, the scan stops and the in-flight read data is kept in a one-entry hold register.
  - The element is sent, to all its destinations together, in the first cycle all of them have cts high.
  - Write-enable is asserted only in cycles where cts is high for every one of that element's destinations.
- Throughput is one element per cycle with no stalls. Scan time is `tile_rows*tile_columns + 2` cycles.
- All outputs reset to 0, and state resets to IDLE. Reset mid-operation drops the in-flight element with no partial send.
- `cycle_done` may assert in the cycle after `exchange_done` first rises, at the earliest.

## Structure
- Package `ppu_pkg`:
  - direction enum N..NW;
  - bitwidth enum with saturation-max constant function;
  - state enum.
- Sub-module `ppu_halo_classifier`: combinational (r,c,H,rows,cols,present) → NEIGHBOR_COUNT destination mask.

## Test plan
- 4×4 tile, kernel 3, all present, all values 5, cts high → 12 edge elements, 20 strobes total; (0,0) hits N, W, NW; exchange_done rises at cycle 18.
- Value −7 at (0,0) and value 0 elsewhere → zero strobes; exchange_done still asserted.
- bitwidth 1, value 100 at (3,3) → E, S and SE receive 15.
- cts[N] low for 10 cycles during scan → the N strobe is delayed 10 cycles; no duplicate or lost element on any port.
- kernel 1 → no reads; `neighbor_present`=8'h0F, neighbor_exchange_done[0..3] raised at cycle 5 → cycle_done pulses at cycle 6, exchange_done falls at cycle 7.
- Reset asserted mid-SCAN → all outputs 0 at once; a new `channel_group_done` restarts at (0,0).
